adder12_arb: RTL and testbench

ADDER12_ARB -- requirements
Module: adder12_arb

---
 rtl/adder12_arb.sv | 107 ++++++++++
 tb/tb_adder12_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder12_arb.sv
// adder12_arb: round-robin arbiter that shares one external 12-bit adder
// between two requesters. A grant in IDLE captures that requester's operands,
// BUSY presents them to the adder for one cycle, and the sum and carry are
// registered on the way back to IDLE together with a one-cycle strobe.
module adder12_arb #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [11:0] a0,
    input  logic [11:0] b0,
    input  logic        req1,
    input  logic [11:0] a1,
    input  logic [11:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [11:0] add_a,
    output logic [11:0] add_b,
    input  logic [11:0] add_sum,
    input  logic        add_cout,
    output logic [11:0] res,
    output logic        res_cout,
    output logic        res_valid,
    output logic        res_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e      state_q;
    // prio_q names the requester that wins a tie; it becomes the loser of
    // the most recent grant, which makes the scheme round-robin.
    logic        prio_q;
    logic [11:0] opa_q;
    logic [11:0] opb_q;
    logic        id_q;
    logic [11:0] res_q;
    logic        res_cout_q;
    logic        res_id_q;
    logic        res_valid_q;
    logic        grant0;
    logic        grant1;

    // Grant decision: only in IDLE, never during reset, tie broken by prio_q.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && (state_q == IDLE)) begin
            if (req0 && req1) begin
                grant0 = ~prio_q;
                grant1 = prio_q;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    // Control FSM: capture on grant, collect the adder result after one BUSY cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prio_q      <= PRIO_INIT;
            opa_q       <= '0;
            opb_q       <= '0;
            id_q        <= 1'b0;
            res_q       <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    res_valid_q <= 1'b0;
                    if (grant0 || grant1) begin
                        opa_q   <= grant1 ? a1 : a0;
                        opb_q   <= grant1 ? b1 : b0;
                        id_q    <= grant1;
                        prio_q  <= ~grant1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    res_q       <= add_sum;
                    res_cout_q  <= add_cout;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0      = grant0;
    assign gnt1      = grant1;
    assign add_a     = (state_q == BUSY) ? opa_q : '0;
    assign add_b     = (state_q == BUSY) ? opb_q : '0;
    assign res       = res_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_adder12_arb.sv
// tb_adder12_arb: self-checking bench for adder12_arb with a transaction-level
// reference model (pending-result queue keyed by due cycle).
module tb_adder12_arb;

    localparam bit PRIO_INIT = 1'b0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [11:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1;
    logic [11:0] add_a, add_b, add_sum, res;
    logic        add_cout, res_cout, res_valid, res_id;

    int n_checks = 0;
    int n_fail   = 0;

    adder12_arb #(.PRIO_INIT(PRIO_INIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_cout(add_cout),
        .res(res), .res_cout(res_cout), .res_valid(res_valid), .res_id(res_id)
    );

    // The shared adder lives outside the block.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct {
        longint      due;
        logic [12:0] sum;
        logic        id;
        logic [11:0] a;
        logic [11:0] b;
    } txn_t;

    txn_t        pend[$];
    longint      cyc;
    longint      rv_cyc;
    logic        m_last;
    logic [12:0] held_sum;
    logic        held_id;

    task automatic model_reset();
        pend.delete();
        cyc      = 0;
        rv_cyc   = -1;
        m_last   = ~PRIO_INIT;
        held_sum = '0;
        held_id  = 1'b0;
    endtask

    function automatic logic model_busy();
        if (pend.size() == 0) return 1'b0;
        return pend[0].due == cyc + 1;
    endfunction

    // {w0,w1}: who the spec says gets accepted this cycle
    function automatic logic [1:0] model_winner();
        if (!reset_n || model_busy()) return 2'b00;
        if (req0 && req1) return m_last ? 2'b10 : 2'b01;
        return {req0, req1};
    endfunction

    function automatic logic [40:0] expect_now();
        logic [11:0] ea, eb;
        ea = '0;
        eb = '0;
        if (model_busy()) begin
            ea = pend[0].a;
            eb = pend[0].b;
        end
        return {model_winner(), ea, eb, (rv_cyc == cyc), held_sum[11:0], held_sum[12], held_id};
    endfunction

    task automatic model_advance();
        logic [1:0] w;
        txn_t t;
        if (!reset_n) begin
            model_reset();
            return;
        end
        w = model_winner();
        if (model_busy()) begin
            t        = pend.pop_front();
            held_sum = t.sum;
            held_id  = t.id;
            rv_cyc   = cyc + 1;
        end
        if (w != 2'b00) begin
            t.due = cyc + 2;
            t.id  = w[0];
            t.a   = w[0] ? a1 : a0;
            t.b   = w[0] ? b1 : b0;
            t.sum = {1'b0, t.a} + {1'b0, t.b};
            pend.push_back(t);
            m_last = w[0];
        end
        cyc++;
    endtask

    function automatic logic [40:0] observed();
        return {gnt0, gnt1, add_a, add_b, res_valid, res, res_cout, res_id};
    endfunction

    function automatic logic [11:0] rand12();
        case ($urandom_range(0, 3))
            0:       return 12'hFFF;
            1:       return 12'h000;
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 12'h123; b0 = 12'h456; a1 = 12'h789; b1 = 12'hABC;
        repeat (2) begin
            @(negedge clock);
            n_checks++;
            if (observed() !== 41'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h required %h", observed(), 41'h0);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        apply_reset();
    endtask

    task automatic test_directed(input logic who, input logic [11:0] a, input logic [11:0] b,
                                 input logic [11:0] sum, input logic cout);
        apply_reset();
        if (who) begin req1 = 1'b1; a1 = a; b1 = b; end
        else     begin req0 = 1'b1; a0 = a; b0 = b; end
        @(negedge clock);
        n_checks++;
        if ({gnt0, gnt1} !== {~who, who}) begin
            n_fail++;
            $display("FAIL directed_grant: got %b required %b", {gnt0, gnt1}, {~who, who});
        end
        @(posedge clock); #1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 12'h555; b0 = 12'h555; a1 = 12'h555; b1 = 12'h555;
        @(negedge clock);
        n_checks++;
        if ({add_a, add_b, res_valid} !== {a, b, 1'b0}) begin
            n_fail++;
            $display("FAIL directed_operands: got %h required %h", {add_a, add_b, res_valid}, {a, b, 1'b0});
        end
        @(negedge clock);
        n_checks++;
        if ({res_valid, res, res_cout, res_id} !== {1'b1, sum, cout, who}) begin
            n_fail++;
            $display("FAIL directed_result: got %h required %h", {res_valid, res, res_cout, res_id}, {1'b1, sum, cout, who});
        end
        @(negedge clock);
        n_checks++;
        if ({res_valid, res, res_cout, res_id, add_a, add_b} !== {1'b0, sum, cout, who, 24'h0}) begin
            n_fail++;
            $display("FAIL directed_hold: got %h required %h", {res_valid, res, res_cout, res_id, add_a, add_b}, {1'b0, sum, cout, who, 24'h0});
        end
    endtask

    task automatic test_alternate();
        int   gq[$];
        int   rq[$];
        logic [40:0] exp;
        req0 = 1'b1; req1 = 1'b1;
        a0 = rand12(); b0 = rand12(); a1 = rand12(); b1 = rand12();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            exp = expect_now();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL alternate cyc %0d: got %h required %h", i, observed(), exp);
            end
            if (gnt0) gq.push_back(0);
            if (gnt1) gq.push_back(1);
            if (res_valid) rq.push_back(int'(res_id));
            @(posedge clock);
            model_advance();
            #1;
        end
        n_checks++;
        if (gq.size() < 3 || rq.size() < 3) begin
            n_fail++;
            $display("FAIL alternate_count: got %0d grants %0d results required 3 each", gq.size(), rq.size());
        end else if ({gq[0], gq[1], gq[2], rq[0], rq[1], rq[2]} !== {0, 1, 0, 0, 1, 0}) begin
            n_fail++;
            $display("FAIL alternate_order: got grants %0d%0d%0d ids %0d%0d%0d required 010 010",
                     gq[0], gq[1], gq[2], rq[0], rq[1], rq[2]);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_req1_alone();
        logic [40:0] exp;
        int ngrant = 0;
        apply_reset();
        req1 = 1'b1; a1 = rand12(); b1 = rand12();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            exp = expect_now();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL req1_alone cyc %0d: got %h required %h", i, observed(), exp);
            end
            if (gnt1) begin
                if (ngrant > 0) begin
                    n_checks++;
                    if (res_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL req1_grant_with_valid cyc %0d: got %b required 1", i, res_valid);
                    end
                end
                ngrant++;
            end
            @(posedge clock);
            model_advance();
            #1;
            if (exp[39]) begin a1 = rand12(); b1 = rand12(); end
        end
        req1 = 1'b0;
    endtask

    task automatic test_busy_req();
        logic [40:0] exp;
        apply_reset();
        req1 = 1'b1; a1 = rand12(); b1 = rand12();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            exp = expect_now();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL busy_req cyc %0d: got %h required %h", i, observed(), exp);
            end
            if (i == 1 || i == 2) begin
                n_checks++;
                if (gnt0 !== (i == 2)) begin
                    n_fail++;
                    $display("FAIL busy_req_gnt0 cyc %0d: got %b required %b", i, gnt0, (i == 2));
                end
            end
            @(posedge clock);
            model_advance();
            #1;
            if (i == 0) begin req1 = 1'b0; req0 = 1'b1; a0 = rand12(); b0 = rand12(); end
            if (i == 2) req0 = 1'b0;
        end
    endtask

    task automatic test_reset_in_busy();
        logic [40:0] exp;
        apply_reset();
        req0 = 1'b1; a0 = 12'h3C5; b0 = 12'h0A1;
        @(negedge clock);
        @(posedge clock);
        model_advance();
        #1;
        req0 = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (observed() !== 41'h0) begin
            n_fail++;
            $display("FAIL reset_in_busy_outputs: got %h required %h", observed(), 41'h0);
        end
        model_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin req1 = 1'b1; a1 = rand12(); b1 = rand12(); end
            @(negedge clock);
            exp = expect_now();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL reset_in_busy_after cyc %0d: got %h required %h", i, observed(), exp);
            end
            @(posedge clock);
            model_advance();
            #1;
            if (exp[39]) req1 = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [40:0] exp;
        logic g0, g1;
        apply_reset();
        g0 = 1'b0; g1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (req0 && g0) begin
                if ($urandom_range(0, 1) == 0) req0 = 1'b0;
                a0 = rand12(); b0 = rand12();
            end else if (!req0) begin
                if ($urandom_range(0, 9) < 4) req0 = 1'b1;
                a0 = rand12(); b0 = rand12();
            end
            if (req1 && g1) begin
                if ($urandom_range(0, 1) == 0) req1 = 1'b0;
                a1 = rand12(); b1 = rand12();
            end else if (!req1) begin
                if ($urandom_range(0, 9) < 4) req1 = 1'b1;
                a1 = rand12(); b1 = rand12();
            end
            @(negedge clock);
            exp = expect_now();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h required %h", i, observed(), exp);
            end
            g0 = exp[40];
            g1 = exp[39];
            @(posedge clock);
            model_advance();
            #1;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed(1'b0, 12'h7FF, 12'h001, 12'h800, 1'b0);
        test_directed(1'b1, 12'hFFF, 12'h001, 12'h000, 1'b1);
        test_alternate();
        test_req1_alone();
        test_busy_req();
        test_reset_in_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
